lcd_bus_receiver: RTL and testbench

Receiving end of the 8-bit HD44780-style parallel LCD bus (lcd_data/lcd_rs/lcd_en) driven by the reaction-timer display logic. Samples each write on the falling edge of lcd_en, decodes instruction and data writes, and maintains a 2x16 character display RAM, address counter and busy flag. Gives the team a synthesizable display endpoint for on-chip self-check and a register-level mirror of what the panel shows.

---
 rtl/lcd_bus_pkg.sv | 35 +++
 rtl/lcd_bus_sync.sv | 34 +++
 rtl/lcd_bus_receiver.sv | 164 ++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the HD44780-style LCD bus receiver.
// Instruction opcodes are matched by mask/match pairs, one pair per highest-set-bit class.
package lcd_bus_pkg;

  typedef enum logic [1:0] {
    INIT_FILL,
    IDLE,
    FILL,
    BUSY
  } rx_state_t;

  localparam int         DDRAM_DEPTH = 32;
  localparam logic [7:0] SPACE_CHAR  = 8'h20;
  localparam logic [4:0] LINE2_BASE  = 5'd16;

  localparam logic [7:0] OP_DDRAM_MASK  = 8'h80, OP_DDRAM_MATCH  = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK  = 8'hC0, OP_CGRAM_MATCH  = 8'h40;
  localparam logic [7:0] OP_FUNC_MASK   = 8'hE0, OP_FUNC_MATCH   = 8'h20;
  localparam logic [7:0] OP_SHIFT_MASK  = 8'hF0, OP_SHIFT_MATCH  = 8'h10;
  localparam logic [7:0] OP_DISP_MASK   = 8'hF8, OP_DISP_MATCH   = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK  = 8'hFC, OP_ENTRY_MATCH  = 8'h04;
  localparam logic [7:0] OP_HOME_MASK   = 8'hFE, OP_HOME_MATCH   = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK  = 8'hFF, OP_CLEAR_MATCH  = 8'h01;

  function automatic logic op_is(input logic [7:0] code, input logic [7:0] mask,
                                 input logic [7:0] match);
    return (code & mask) == match;
  endfunction

  // Address counter step; 5-bit wrap gives 31->0, 0->31 and 15->16 line crossing.
  function automatic logic [4:0] ac_step(input logic [4:0] addr, input logic up);
    return up ? addr + 5'd1 : addr - 5'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus lcd_en falling-edge detect.
// rs/data are taken from the same synchronized stage as the edge so they stay coherent.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic [7:0] lcd_data,
  output logic       strobe,
  output logic       rs,
  output logic [7:0] data
);

  logic [9:0] meta;
  logic [9:0] stable;
  logic       en_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= '0;
      stable  <= '0;
      en_prev <= 1'b0;
    end else begin
      meta    <= {lcd_en, lcd_rs, lcd_data};
      stable  <= meta;
      en_prev <= stable[9];
    end
  end

  assign strobe = en_prev & ~stable[9];
  assign rs     = stable[8];
  assign data   = stable[7:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// 2x16 HD44780-style display endpoint: decodes bus writes into DDRAM, address counter and busy.
// Define LCD_RX_BUSY_MODEL_EN to model command busy times; otherwise only fills report busy.
module lcd_bus_receiver
  import lcd_bus_pkg::*;
#(
  parameter int BUSY_CYCLES       = 1850,
  parameter int CLEAR_BUSY_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic       overrun_err,
  input  logic       err_clear
);

`ifdef LCD_RX_BUSY_MODEL_EN
  localparam bit BUSY_MODEL = 1'b1;
`else
  localparam bit BUSY_MODEL = 1'b0;
`endif

  localparam int             CNT_W      = $clog2(CLEAR_BUSY_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [4:0]       LAST_IDX   = 5'(DDRAM_DEPTH - 1);

  logic       sync_strobe;
  logic       sync_rs;
  logic [7:0] sync_data;

  rx_state_t        state, next_state;
  logic [4:0]       fill_idx, next_fill;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [4:0]       ac, next_ac;
  logic             id_inc, next_id;
  logic             next_disp;
  logic             accept;
  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem [DDRAM_DEPTH];

  lcd_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .strobe   (sync_strobe),
    .rs       (sync_rs),
    .data     (sync_data)
  );

  always_comb begin
    next_state = state;
    next_fill  = fill_idx;
    next_cnt   = cnt;
    next_ac    = ac;
    next_id    = id_inc;
    next_disp  = display_on;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ac;
    mem_wdata  = sync_data;

    case (state)
      INIT_FILL, FILL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_idx;
        mem_wdata = SPACE_CHAR;
        next_fill = fill_idx + 5'd1;
        if (state == FILL) next_cnt = cnt - CNT_ONE;
        // Clear busy runs across the fill; BUSY covers only what the fill did not use.
        if (fill_idx == LAST_IDX) begin
          if (state == FILL && BUSY_MODEL && cnt != '0) next_state = BUSY;
          else                                          next_state = IDLE;
        end
      end

      IDLE: begin
        if (sync_strobe) begin
          accept = 1'b1;
          if (BUSY_MODEL) begin
            next_state = BUSY;
            next_cnt   = BUSY_LOAD;
          end
          if (sync_rs) begin
            mem_we    = 1'b1;
            mem_waddr = ac;
            next_ac   = ac_step(ac, id_inc);
          end else if (op_is(sync_data, OP_DDRAM_MASK, OP_DDRAM_MATCH)) begin
            next_ac = (sync_data[6] ? LINE2_BASE : 5'd0) | {1'b0, sync_data[3:0]};
          end else if (op_is(sync_data, OP_CGRAM_MASK, OP_CGRAM_MATCH) ||
                       op_is(sync_data, OP_FUNC_MASK, OP_FUNC_MATCH)) begin
            next_ac = ac;
          end else if (op_is(sync_data, OP_SHIFT_MASK, OP_SHIFT_MATCH)) begin
            if (!sync_data[3]) next_ac = ac_step(ac, sync_data[2]);
          end else if (op_is(sync_data, OP_DISP_MASK, OP_DISP_MATCH)) begin
            next_disp = sync_data[2];
          end else if (op_is(sync_data, OP_ENTRY_MASK, OP_ENTRY_MATCH)) begin
            next_id = sync_data[1];
          end else if (op_is(sync_data, OP_HOME_MASK, OP_HOME_MATCH)) begin
            next_ac = '0;
            if (BUSY_MODEL) next_cnt = CLEAR_LOAD;
          end else if (op_is(sync_data, OP_CLEAR_MASK, OP_CLEAR_MATCH)) begin
            next_ac    = '0;
            next_id    = 1'b1;
            next_state = FILL;
            next_fill  = '0;
            next_cnt   = CLEAR_LOAD;
          end
        end
      end

      BUSY: begin
        if (cnt == '0) next_state = IDLE;
        else           next_cnt   = cnt - CNT_ONE;
      end

      default: next_state = INIT_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT_FILL;
      fill_idx    <= '0;
      cnt         <= '0;
      ac          <= '0;
      id_inc      <= 1'b1;
      display_on  <= 1'b0;
      overrun_err <= 1'b0;
      rd_char     <= '0;
    end else begin
      state      <= next_state;
      fill_idx   <= next_fill;
      cnt        <= next_cnt;
      ac         <= next_ac;
      id_inc     <= next_id;
      display_on <= next_disp;
      rd_char    <= mem[rd_addr];
      if (sync_strobe && state != IDLE) overrun_err <= 1'b1;
      else if (err_clear)               overrun_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy        = (state != IDLE);
  assign wr_strobe   = accept;
  assign cursor_addr = ac;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: table of bus writes with expected AC/display/DDRAM,
// plus hand sequences for overrun, err_clear priority, clear and reset during fill.
`timescale 1ns/1ps
module tb_lcd_bus_receiver;

  localparam int BUSY_N  = 20;
  localparam int CLEAR_N = 60;
`ifdef LCD_RX_BUSY_MODEL_EN
  localparam int EXP_NORMAL = BUSY_N;
  localparam int EXP_HOME   = CLEAR_N;
  localparam int EXP_CLEAR  = CLEAR_N;
`else
  localparam int EXP_NORMAL = 0;
  localparam int EXP_HOME   = 0;
  localparam int EXP_CLEAR  = 32;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_en = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [4:0] cursor_addr;
  logic       display_on;
  logic       busy;
  logic       wr_strobe;
  logic       overrun_err;
  logic       err_clear = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int busy_run = 0;
  int last_busy_len = -1;
  bit tracking = 1'b0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] rd_idx;
    logic [7:0] exp_char;
    logic [4:0] exp_ac;
    logic       exp_disp;
    int         exp_busy;
  } vec_t;

  vec_t vecs[20];

  lcd_bus_receiver #(.BUSY_CYCLES(BUSY_N), .CLEAR_BUSY_CYCLES(CLEAR_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .lcd_en      (lcd_en),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .busy        (busy),
    .wr_strobe   (wr_strobe),
    .overrun_err (overrun_err),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  // Counts accepted writes and measures how long busy stays high after each one.
  always @(negedge clk) begin
    if (reset) begin
      tracking = 1'b0;
    end else if (wr_strobe) begin
      strobe_cnt++;
      busy_run = 0;
      tracking = 1'b1;
      last_busy_len = -1;
    end else if (tracking) begin
      if (busy) busy_run++;
      else begin
        tracking = 1'b0;
        last_busy_len = busy_run;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_data = d;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < CLEAR_N + 100 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("idle_timeout", idle, 1);
    @(negedge clk);
  endtask

  task automatic read_ram(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_char;
  endtask

  task automatic check_all_spaces(input string tag);
    logic [7:0] d;
    for (int a = 0; a < 32; a++) begin
      read_ram(5'(a), d);
      check($sformatf("%s_ram%0d", tag, a), d, 8'h20);
    end
  endtask

  task automatic release_and_time_fill(input string tag);
    int  n_busy = 0;
    bit  dropped = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      else dropped = 1'b1;
    end
    check({tag, "_fill_len"}, n_busy, 32);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] d;
    int base;

    vecs[0]  = '{1'b1, 8'h41, 5'd0,  8'h41, 5'd1,  1'b0, EXP_NORMAL};
    vecs[1]  = '{1'b1, 8'h42, 5'd1,  8'h42, 5'd2,  1'b0, EXP_NORMAL};
    vecs[2]  = '{1'b0, 8'hC0, 5'd16, 8'h20, 5'd16, 1'b0, EXP_NORMAL};
    vecs[3]  = '{1'b1, 8'h39, 5'd16, 8'h39, 5'd17, 1'b0, EXP_NORMAL};
    vecs[4]  = '{1'b0, 8'h0C, 5'd0,  8'h41, 5'd17, 1'b1, EXP_NORMAL};
    vecs[5]  = '{1'b0, 8'h10, 5'd1,  8'h42, 5'd16, 1'b1, EXP_NORMAL};
    vecs[6]  = '{1'b0, 8'h14, 5'd16, 8'h39, 5'd17, 1'b1, EXP_NORMAL};
    vecs[7]  = '{1'b0, 8'h18, 5'd17, 8'h20, 5'd17, 1'b1, EXP_NORMAL};
    vecs[8]  = '{1'b0, 8'h8F, 5'd15, 8'h20, 5'd15, 1'b1, EXP_NORMAL};
    vecs[9]  = '{1'b1, 8'h5A, 5'd15, 8'h5A, 5'd16, 1'b1, EXP_NORMAL};
    vecs[10] = '{1'b0, 8'hFF, 5'd31, 8'h20, 5'd31, 1'b1, EXP_NORMAL};
    vecs[11] = '{1'b1, 8'h58, 5'd31, 8'h58, 5'd0,  1'b1, EXP_NORMAL};
    vecs[12] = '{1'b0, 8'h04, 5'd0,  8'h41, 5'd0,  1'b1, EXP_NORMAL};
    vecs[13] = '{1'b1, 8'h5B, 5'd0,  8'h5B, 5'd31, 1'b1, EXP_NORMAL};
    vecs[14] = '{1'b0, 8'h38, 5'd31, 8'h58, 5'd31, 1'b1, EXP_NORMAL};
    vecs[15] = '{1'b0, 8'h40, 5'd1,  8'h42, 5'd31, 1'b1, EXP_NORMAL};
    vecs[16] = '{1'b0, 8'h08, 5'd16, 8'h39, 5'd31, 1'b0, EXP_NORMAL};
    vecs[17] = '{1'b0, 8'h02, 5'd0,  8'h5B, 5'd0,  1'b0, EXP_HOME};
    vecs[18] = '{1'b0, 8'h06, 5'd15, 8'h5A, 5'd0,  1'b0, EXP_NORMAL};
    vecs[19] = '{1'b0, 8'hB5, 5'd5,  8'h20, 5'd5,  1'b0, EXP_NORMAL};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_cursor", cursor_addr, 0);
    check("rst_display_on", display_on, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_overrun", overrun_err, 0);
    check("rst_rd_char", rd_char, 0);

    release_and_time_fill("init");
    check("init_busy_low", busy, 0);
    check("init_cursor", cursor_addr, 0);
    check_all_spaces("init");

    for (int i = 0; i < 20; i++) begin
      lcd_write(vecs[i].rs, vecs[i].data);
      wait_idle();
      check($sformatf("vec%0d_cursor", i), cursor_addr, vecs[i].exp_ac);
      check($sformatf("vec%0d_display_on", i), display_on, vecs[i].exp_disp);
      check($sformatf("vec%0d_busy_len", i), last_busy_len, vecs[i].exp_busy);
      read_ram(vecs[i].rd_idx, d);
      check($sformatf("vec%0d_ram%0d", i, vecs[i].rd_idx), d, vecs[i].exp_char);
    end
    check("vec_strobe_count", strobe_cnt, 20);
    check("vec_overrun", overrun_err, 0);

`ifdef LCD_RX_BUSY_MODEL_EN
    base = strobe_cnt;
    lcd_write(1'b1, 8'h51);
    lcd_write(1'b1, 8'h52);
    wait_idle();
    check("busy_drop_strobes", strobe_cnt, base + 1);
    check("busy_drop_cursor", cursor_addr, 6);
    check("busy_drop_overrun", overrun_err, 1);
    read_ram(5'd5, d);
    check("busy_drop_ram5", d, 8'h51);
    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
`endif

    lcd_write(1'b0, 8'h04);
    wait_idle();
    base = strobe_cnt;
    lcd_write(1'b0, 8'h01);
    lcd_write(1'b1, 8'h77);
    wait_idle();
    check("clr_strobes", strobe_cnt, base + 1);
    check("clr_overrun", overrun_err, 1);
    check("clr_busy_len", last_busy_len, EXP_CLEAR);
    check("clr_cursor", cursor_addr, 0);
    check_all_spaces("clr");
    lcd_write(1'b1, 8'h61);
    wait_idle();
    check("clr_id_restored", cursor_addr, 1);
    read_ram(5'd0, d);
    check("clr_ram0_after", d, 8'h61);

    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
    check("err_clear", overrun_err, 0);

    // Overrun strobe lands in the same cycle as err_clear: the set must win.
    lcd_write(1'b0, 8'h01);
    @(negedge clk);
    lcd_rs = 1'b1;
    lcd_data = 8'h62;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("set_beats_clear", overrun_err, 1);
    wait_idle();

    lcd_write(1'b1, 8'h63);
    wait_idle();
    lcd_write(1'b0, 8'h0C);
    wait_idle();
    check("pre_rst_display_on", display_on, 1);
    lcd_write(1'b0, 8'h01);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midfill_rst_busy", busy, 1);
    check("midfill_rst_display_on", display_on, 0);
    check("midfill_rst_overrun", overrun_err, 0);
    release_and_time_fill("midfill");
    check("midfill_cursor", cursor_addr, 0);
    check_all_spaces("midfill");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
